pi_req_latch: RTL and testbench

- Upstream request-capture stage for the parameterized priority encoder (2**SIZE request lines in, SIZE-bit index out).
- Synchronizes asynchronous request lines and detects their rising edges.
- Each edge is held in a sticky pending bit until the consumer acknowledges that channel by index.
- The masked pending vector drives the encoder's input bus directly. The block also flags lost events and keeps a saturating count of accepted events.

---
 rtl/pi_req_latch_if.sv | 9 +
 rtl/pi_req_latch.sv | 41 ++++
 tb/tb_pi_req_latch.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pi_req_latch_if.sv
// pi_req_latch_if: bundle between asynchronous requesters, the request latch and the priority encoder
interface pi_req_latch_if #(parameter int SIZE = 2, parameter int CNT_W = 8);
    logic [2**SIZE-1:0] req_in, mask, pend_out, missed;
    logic ack, any_pend;
    logic [SIZE-1:0] ack_idx;
    logic [CNT_W-1:0] evt_cnt;
    modport master (output req_in, mask, ack, ack_idx, input pend_out, any_pend, missed, evt_cnt);
    modport slave (input req_in, mask, ack, ack_idx, output pend_out, any_pend, missed, evt_cnt);
endinterface

// File: rtl/pi_req_latch.sv
// pi_req_latch: synchronizes request lines, latches rising edges until acked by index
module pi_req_latch #(parameter int SIZE = 2, parameter int CNT_W = 8) (
    input logic clk,
    input logic rst,
    pi_req_latch_if.slave bus
);
    localparam int N = 2**SIZE;
    localparam int W = CNT_W + SIZE + 1;
    localparam logic [CNT_W-1:0] MAX = '1;
    logic [N-1:0] s1, s2, s3, pend, miss, acc, clr;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0] sum;
    assign acc = s2 & ~s3 & ~bus.mask;
    assign clr = bus.ack ? N'(1) << bus.ack_idx : '0;
    always_comb begin
        sum = W'(cnt);
        for (int i = 0; i < N; i++) sum = sum + W'(acc[i]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            pend <= '0;
            miss <= '0;
            cnt <= '0;
        end else begin
            s1 <= bus.req_in;
            s2 <= s1;
            s3 <= s2;
            pend <= acc | (pend & ~clr);
            miss <= ((acc & pend) | miss) & ~clr;
            cnt <= sum > W'(MAX) ? MAX : sum[CNT_W-1:0];
        end
    end
    // visibility is gated combinationally so unmasking reveals a held request immediately
    assign bus.pend_out = pend & ~bus.mask;
    assign bus.any_pend = |bus.pend_out;
    assign bus.missed = miss;
    assign bus.evt_cnt = cnt;
endmodule

// File: tb/tb_pi_req_latch.sv
// tb_pi_req_latch: directed scenarios for the request latch with a 2-bit saturating counter
module tb_pi_req_latch;
    logic clk = 0, rst = 1;
    int n_chk = 0, n_fail = 0;
    pi_req_latch_if #(.SIZE(2), .CNT_W(2)) bus ();
    pi_req_latch #(.SIZE(2), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; bus.req_in = '0; bus.mask = '0; bus.ack = 0; bus.ack_idx = '0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic pulse(input logic [3:0] r);
        bus.req_in = r; tick(); bus.req_in = '0; tick(); tick();
    endtask

    function automatic int enc(input logic [3:0] v);
        enc = 0;
        for (int i = 0; i < 4; i++) if (v[i]) enc = i;
    endfunction

    task automatic test_reset();
        rst = 1; bus.req_in = 4'b1010; bus.mask = '0; bus.ack = 0; bus.ack_idx = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL rst_pend got %b want 0000", bus.pend_out); end
            n_chk++; if (bus.missed !== 4'b0000) begin n_fail++; $display("FAIL rst_missed got %b want 0000", bus.missed); end
            n_chk++; if (bus.evt_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", bus.evt_cnt); end
        end
        rst = 0;
        tick(); tick();
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL rel_early got %b want 0000", bus.pend_out); end
        tick();
        n_chk++; if (bus.pend_out !== 4'b1010) begin n_fail++; $display("FAIL rel_pend got %b want 1010", bus.pend_out); end
        n_chk++; if (bus.any_pend !== 1'b1) begin n_fail++; $display("FAIL rel_any got %b want 1", bus.any_pend); end
        n_chk++; if (bus.evt_cnt !== 2'd2) begin n_fail++; $display("FAIL rel_cnt got %0d want 2", bus.evt_cnt); end
        bus.req_in = '0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req_in = 4'b0100; tick(); bus.req_in = '0; tick();
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL lat_k1 got %b want 0000", bus.pend_out); end
        tick();
        n_chk++; if (bus.pend_out !== 4'b0100) begin n_fail++; $display("FAIL lat_k2 got %b want 0100", bus.pend_out); end
        n_chk++; if (bus.any_pend !== 1'b1) begin n_fail++; $display("FAIL lat_any got %b want 1", bus.any_pend); end
        tick(); tick();
        n_chk++; if (bus.pend_out !== 4'b0100) begin n_fail++; $display("FAIL sticky got %b want 0100", bus.pend_out); end
        bus.ack = 1; bus.ack_idx = 2; tick(); bus.ack = 0;
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL ack_clr got %b want 0000", bus.pend_out); end
        n_chk++; if (bus.any_pend !== 1'b0) begin n_fail++; $display("FAIL ack_any got %b want 0", bus.any_pend); end
        n_chk++; if (bus.evt_cnt !== 2'd1) begin n_fail++; $display("FAIL single_cnt got %0d want 1", bus.evt_cnt); end
    endtask

    task automatic test_missed();
        do_reset();
        pulse(4'b0010);
        bus.ack = 1; bus.ack_idx = 0; tick(); bus.ack = 0;
        n_chk++; if (bus.pend_out !== 4'b0010) begin n_fail++; $display("FAIL ack_idle got %b want 0010", bus.pend_out); end
        pulse(4'b0010);
        n_chk++; if (bus.missed !== 4'b0010) begin n_fail++; $display("FAIL missed_set got %b want 0010", bus.missed); end
        n_chk++; if (bus.evt_cnt !== 2'd2) begin n_fail++; $display("FAIL missed_cnt got %0d want 2", bus.evt_cnt); end
        bus.ack = 1; bus.ack_idx = 1; tick(); bus.ack = 0;
        n_chk++; if (bus.missed !== 4'b0000) begin n_fail++; $display("FAIL missed_clr got %b want 0000", bus.missed); end
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL missed_pclr got %b want 0000", bus.pend_out); end
        do_reset();
        pulse(4'b0010);
        bus.req_in = 4'b0010; tick(); bus.req_in = '0; tick();
        bus.ack = 1; bus.ack_idx = 1; tick(); bus.ack = 0;
        n_chk++; if (bus.pend_out !== 4'b0010) begin n_fail++; $display("FAIL same_pend got %b want 0010", bus.pend_out); end
        n_chk++; if (bus.missed !== 4'b0000) begin n_fail++; $display("FAIL same_missed got %b want 0000", bus.missed); end
        n_chk++; if (bus.evt_cnt !== 2'd2) begin n_fail++; $display("FAIL same_cnt got %0d want 2", bus.evt_cnt); end
    endtask

    task automatic test_mask();
        do_reset();
        bus.mask = 4'b0001; pulse(4'b0001);
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL mask_drop got %b want 0000", bus.pend_out); end
        n_chk++; if (bus.evt_cnt !== 2'd0) begin n_fail++; $display("FAIL mask_cnt got %0d want 0", bus.evt_cnt); end
        bus.mask = '0; #1;
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL mask_nodefer got %b want 0000", bus.pend_out); end
        pulse(4'b1000);
        n_chk++; if (bus.pend_out !== 4'b1000) begin n_fail++; $display("FAIL ch3_pend got %b want 1000", bus.pend_out); end
        bus.mask = 4'b1000; #1;
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL mask_hide got %b want 0000", bus.pend_out); end
        n_chk++; if (bus.any_pend !== 1'b0) begin n_fail++; $display("FAIL mask_any got %b want 0", bus.any_pend); end
        bus.mask = '0; #1;
        n_chk++; if (bus.pend_out !== 4'b1000) begin n_fail++; $display("FAIL unmask got %b want 1000", bus.pend_out); end
        bus.mask = 4'b1000; bus.ack = 1; bus.ack_idx = 3; tick(); bus.ack = 0; bus.mask = '0; #1;
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL mask_ack got %b want 0000", bus.pend_out); end
        n_chk++; if (bus.evt_cnt !== 2'd1) begin n_fail++; $display("FAIL mask_cnt2 got %0d want 1", bus.evt_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse(4'b1111);
        n_chk++; if (bus.pend_out !== 4'b1111) begin n_fail++; $display("FAIL all_pend got %b want 1111", bus.pend_out); end
        n_chk++; if (bus.evt_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got %0d want 3", bus.evt_cnt); end
        pulse(4'b0001);
        n_chk++; if (bus.evt_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_hold got %0d want 3", bus.evt_cnt); end
        n_chk++; if (bus.missed !== 4'b0001) begin n_fail++; $display("FAIL sat_missed got %b want 0001", bus.missed); end
        for (int b = 3; b >= 0; b--) begin
            n_chk++; if (enc(bus.pend_out) !== b) begin n_fail++; $display("FAIL enc got %0d want %0d", enc(bus.pend_out), b); end
            bus.ack = 1; bus.ack_idx = 2'(b); tick(); bus.ack = 0;
        end
        n_chk++; if (bus.any_pend !== 1'b0) begin n_fail++; $display("FAIL drain_any got %b want 0", bus.any_pend); end
        n_chk++; if (bus.missed !== 4'b0000) begin n_fail++; $display("FAIL drain_missed got %b want 0000", bus.missed); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_in = 4'b0100; tick(); tick();
        rst = 1; bus.req_in = '0; tick();
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL mid_pend got %b want 0000", bus.pend_out); end
        n_chk++; if (bus.evt_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", bus.evt_cnt); end
        rst = 0; tick(); tick(); tick();
        n_chk++; if (bus.pend_out !== 4'b0000) begin n_fail++; $display("FAIL mid_lost got %b want 0000", bus.pend_out); end
        n_chk++; if (bus.evt_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_cnt2 got %0d want 0", bus.evt_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_missed();
        test_mask();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
